sr_flag_arbiter: RTL and testbench
==================================

# sr_flag_arbiter

Shared bank of NFLAG SR-semantics status flags written by NREQ independent requesters through a valid/ready handshake. A round-robin arbiter grants one write per cycle, so two agents never drive the same flag bank in the same cycle. The grant is applied with set/reset/hold rules; `11` is treated as hold, never as an illegal state. The block sits between control agents (FSMs, interrupt sources) and downstream logic that reads the flag vector.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `NFLAG`, default 8: number of flags (2..32). `IW = $clog2(NFLAG)`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input NREQ: per-requester request valid.
- `req_op` input 2*NREQ: per-requester `{s,r}`, requester i at bits [2i+1:2i].
- `req_idx` input IW*NREQ: per-requester target flag index, requester i at [IW*i+IW-1:IW*i].
- `req_ready` output NREQ: one-hot grant (combinational); transfer when `req_valid[i] & req_ready[i]`.
- `flags` output NFLAG: registered flag state.
- `grant_vld` output 1: registered; a transfer occurred in the previous cycle.
- `grant_id` output $clog2(NREQ): registered id of last granted requester.
- `contention_cnt` output 8: saturating count of cycles with ≥2 valid requests.

## Operation
- Arbiter state: round-robin pointer `ptr` (0..NREQ-1), initial priority holder.
- Each cycle: grant lowest `(i - ptr) mod NREQ` among asserted `req_valid`; exactly one `req_ready` bit high if any valid, else all zero.
- `req_ready` depends only on `req_valid` and `ptr`, never on `req_op`/`req_idx`.
- On transfer from requester g at edge, to `flags[req_idx_g]`:
  - `00`: hold.
  - `01`: flag ← 0.
  - `10`: flag ← 1.
  - `11`: hold.
- All other flags hold. Transfer is still acknowledged for `00`/`11` ops.
- `req_idx ≥ NFLAG`: no flag changes; transfer still acknowledged and counted in `grant_vld`.
- On transfer: `ptr ← (g+1) mod NREQ`. No transfer: `ptr` holds.
- `contention_cnt` increments when popcount(`req_valid`) ≥ 2 and saturates at 255.
- Requesters hold `valid`/`op`/`idx` stable until ready. Changing them while waiting is allowed; the block samples only the granted cycle's values.

## Timing
- Reset (`rst_n`=0 at edge) forces the following; ready is forced to 0 while `rst_n` is low:
  - `flags`=0.
  - `ptr`=0.
  - `grant_vld`=0.
  - `grant_id`=0.
  - `contention_cnt`=0.
  - `req_ready`=0.
- Reset mid-stream: a pending request with `rst_n` low is not granted and has no effect. Arbitration resumes from `ptr`=0 on the first cycle with `rst_n` high.
- Grant latency: 0 cycles (ready in same cycle as valid when highest priority).
- Flag update latency: `flags` reflects the transfer one cycle after the handshake edge. `grant_vld`/`grant_id` are valid in the same cycle.
- Throughput: 1 transfer/cycle. Worst-case wait for a continuously valid requester: NREQ-1 cycles.
- Same flag targeted by requesters in consecutive cycles: applied in grant order, and the later one wins.

## Test plan
- Reset: drive random inputs with `rst_n`=0 for 3 cycles. Expected: `flags`=0, `req_ready`=0, `contention_cnt`=0, `grant_vld`=0.
- Single requester, ops applied in sequence:
  - req 2 writes `10` to idx 5. Expected: same-cycle `req_ready`=4'b0100; next cycle `flags`=8'h20, `grant_id`=2.
  - Then `01` to idx 5. Expected: `flags`=0.
  - Then `11` to idx 5 (after another `10`). Expected: stays 8'h20.
- Fairness: all 4 valid continuously, each setting flag idx=i, from `ptr`=0.
  - Expected grants 0,1,2,3,0.
  - `flags` progresses 01,03,07,0F.
  - `contention_cnt` increments every cycle.
- Out-of-range and saturation:
  - With NFLAG=8, `req_idx`=9 with `10` (IW=3 build uses NFLAG=6, idx 7). Expected: acked, `flags` unchanged.
  - Hold 2 valid requests 300 cycles. Expected: `contention_cnt`=255.
- Reset mid-operation: set flags to 8'hFF, `ptr`=3, then pulse `rst_n` low 1 cycle with req 1 and 3 valid.
  - Expected: `flags`=0.
  - First grant after reset goes to req 1.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of SR flags: one valid/ready write per cycle,
// applied as set/clear/hold to a single indexed flag.
module sr_flag_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int NFLAG = 8,
  localparam int IW    = $clog2(NFLAG),
  localparam int GW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IW*NREQ-1:0]   req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFLAG-1:0]     flags,
  output logic                 grant_vld,
  output logic [GW-1:0]        grant_id,
  output logic [7:0]           contention_cnt
);

  logic [GW-1:0]   ptr;
  logic [NREQ-1:0] gnt;
  logic [GW-1:0]   gid;
  logic            found;
  logic            xfer;
  logic            multi;
  logic [1:0]      op_g;
  logic [IW-1:0]   idx_g;

  // Scan from ptr upward; the first valid requester met has highest priority.
  always_comb begin
    int unsigned j;
    j     = 0;
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && req_valid[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gid    = GW'(j);
      end
    end
  end

  assign req_ready = rst_n ? gnt : '0;
  assign xfer      = |req_ready;
  assign multi     = $countones(req_valid) >= 2;
  assign op_g      = req_op[2*int'(gid) +: 2];
  assign idx_g     = req_idx[IW*int'(gid) +: IW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags          <= '0;
      ptr            <= '0;
      grant_vld      <= 1'b0;
      grant_id       <= '0;
      contention_cnt <= '0;
    end else begin
      grant_vld <= xfer;
      if (xfer) begin
        grant_id <= gid;
        ptr      <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
        // Out-of-range indices are acknowledged but leave every flag untouched.
        if (int'(idx_g) < NFLAG) begin
          case (op_g)
            2'b10:   flags[idx_g] <= 1'b1;
            2'b01:   flags[idx_g] <= 1'b0;
            default: ;
          endcase
        end
      end
      if (multi && contention_cnt != 8'hFF)
        contention_cnt <= contention_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: default build plus an NFLAG=6 build
// sharing the same stimulus for the out-of-range index case.
module tb_sr_flag_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [11:0] req_idx;

  logic [3:0]  req_ready;
  logic [7:0]  flags;
  logic        grant_vld;
  logic [1:0]  grant_id;
  logic [7:0]  contention_cnt;

  logic [3:0]  req_ready6;
  logic [5:0]  flags6;
  logic        grant_vld6;
  logic [1:0]  grant_id6;
  logic [7:0]  contention_cnt6;

  int checks = 0;
  int errors = 0;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .flags(flags),
    .grant_vld(grant_vld), .grant_id(grant_id), .contention_cnt(contention_cnt)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready6), .flags(flags6),
    .grant_vld(grant_vld6), .grant_id(grant_id6), .contention_cnt(contention_cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] o, input logic [2:0] x);
    req_valid[i]       = v;
    req_op[2*i +: 2]   = o;
    req_idx[3*i +: 3]  = x;
  endtask

  logic [7:0] fair_flags [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_idx   = '0;

    // Reset with random inputs
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom());
      req_op    = 8'($urandom());
      req_idx   = 12'($urandom());
      #1;
      check("rst_ready", 32'(req_ready), 32'h0);
      tick();
    end
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_cnt", 32'(contention_cnt), 32'h0);
    check("rst_gvld", 32'(grant_vld), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);

    // Single requester 2 on flag 5
    rst_n = 1'b1;
    req_valid = '0;
    set_req(2, 1'b1, 2'b10, 3'd5);
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    check("set_flags", 32'(flags), 32'h20);
    check("set_gid", 32'(grant_id), 32'h2);
    check("set_gvld", 32'(grant_vld), 32'h1);
    set_req(2, 1'b1, 2'b01, 3'd5);
    tick();
    check("clr_flags", 32'(flags), 32'h0);
    set_req(2, 1'b1, 2'b10, 3'd5);
    tick();
    check("reset_flags", 32'(flags), 32'h20);
    set_req(2, 1'b1, 2'b11, 3'd5);
    tick();
    check("hold11_flags", 32'(flags), 32'h20);
    check("hold11_gvld", 32'(grant_vld), 32'h1);
    req_valid = '0;
    tick();
    check("idle_gvld", 32'(grant_vld), 32'h0);
    check("idle_cnt", 32'(contention_cnt), 32'h0);

    // Fairness from ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b10, 3'(i));
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
      check("rr_gid", 32'(grant_id), 32'(c % 4));
      check("rr_flags", 32'(fair_flags[c]), 32'(flags));
      check("rr_cnt", 32'(contention_cnt), 32'(c + 1));
    end

    // Out-of-range index on the NFLAG=6 build (ptr now 1, only req0 valid)
    req_valid = '0;
    set_req(0, 1'b1, 2'b10, 3'd7);
    #1;
    check("oor_ready6", 32'(req_ready6), 32'h1);
    tick();
    check("oor_flags6", 32'(flags6), 32'h0F);
    check("oor_gvld6", 32'(grant_vld6), 32'h1);
    check("oor_gid6", 32'(grant_id6), 32'h0);
    check("inr_flags8", 32'(flags), 32'h8F);

    // Saturation: two holds valid continuously, count starts at 5
    set_req(0, 1'b1, 2'b00, 3'd0);
    set_req(1, 1'b1, 2'b00, 3'd1);
    for (int c = 0; c < 249; c++) tick();
    check("sat_254", 32'(contention_cnt), 32'd254);
    tick();
    check("sat_255", 32'(contention_cnt), 32'd255);
    for (int c = 0; c < 50; c++) tick();
    check("sat_hold", 32'(contention_cnt), 32'd255);
    check("sat_flags", 32'(flags), 32'h8F);

    // Fill all flags with req0 alone, then one req2 grant leaves ptr=3
    req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 2'b10, 3'(i));
      tick();
    end
    req_valid = '0;
    set_req(2, 1'b1, 2'b00, 3'd0);
    tick();
    check("fill_flags", 32'(flags), 32'hFF);
    check("fill_gid", 32'(grant_id), 32'h2);

    // Reset pulse with req1 and req3 pending
    req_valid = '0;
    set_req(1, 1'b1, 2'b10, 3'd0);
    set_req(3, 1'b1, 2'b10, 3'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("mid_rst_flags", 32'(flags), 32'h0);
    check("mid_rst_gvld", 32'(grant_vld), 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    check("post_rst_gid", 32'(grant_id), 32'h1);
    check("post_rst_flags", 32'(flags), 32'h01);
    check("post_rst_cnt", 32'(contention_cnt), 32'h1);
    #1;
    check("post_rst_ready2", 32'(req_ready), 32'h8);
    tick();
    check("post_rst_flags2", 32'(flags), 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
